// File: rtl/instr_stager.sv
// instr_stager - instruction staging buffer in front of the processor.
//
// Assembles 4-bit nibbles MSB-first into 12-bit instructions and stores up
// to DEPTH of them. On start it releases the processor from reset and streams
// the stored program one instruction per cycle, then parks in DONE with the
// processor held in reset again.
//
// Optional feature: define INSTR_STAGER_REPLAY_EN to let start re-run the
// stored program from DONE. Without it only clear or reset leaves DONE.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high
//   nib_in       instruction nibble (first nibble is bits [11:8])
//   nib_valid    nib_in valid this cycle
//   nib_ready    nibble accepted when nib_valid && nib_ready (combinational)
//   start        request program run (level)
//   clear        synchronous flush to empty IDLE
//   instruction  registered instruction to the processor
//   instr_valid  instruction holds a live program word
//   proc_reset   registered active-high reset to the processor
//   count        number of stored complete instructions
//   done         program fully issued
//   overflow     sticky: a nibble was offered while nib_ready was low

module instr_stager #(
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [3:0]                 nib_in,
  input  logic                       nib_valid,
  output logic                       nib_ready,
  input  logic                       start,
  input  logic                       clear,
  output logic [11:0]                instruction,
  output logic                       instr_valid,
  output logic                       proc_reset,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       done,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [1:0]      nib_cnt_r;
  logic [7:0]      asm_r;          // upper two nibbles of the word being built
  logic [11:0]     mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   issued_r;       // instructions issued so far in this run
  logic [11:0]     instruction_r;
  logic            instr_valid_r;
  logic            proc_reset_r;
  logic            done_r;
  logic            overflow_r;

  logic            nib_ready_s;
  logic            accept_s;
  logic            write_s;
  logic            launch_s;
  logic            last_s;
  logic            ovf_set_s;

  assign nib_ready   = nib_ready_s;
  assign instruction = instruction_r;
  assign instr_valid = instr_valid_r;
  assign proc_reset  = proc_reset_r;
  assign count       = count_r;
  assign done        = done_r;
  assign overflow    = overflow_r;

  // Handshake and control strobes, and FSM next-state.
  always_comb begin
    state_s     = state_r;
    nib_ready_s = 1'b0;
    launch_s    = 1'b0;

    if (((state_r == ST_IDLE) || (state_r == ST_LOAD)) && (count_r < DEPTH_C)) begin
      nib_ready_s = 1'b1;
    end else begin
      nib_ready_s = 1'b0;
    end

    accept_s  = nib_valid && nib_ready_s && !clear;
    write_s   = accept_s && (nib_cnt_r == 2'd2);
    ovf_set_s = nib_valid && !nib_ready_s && !clear;
    last_s    = (state_r == ST_RUN) && (issued_r == count_r);

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Only a complete, non-empty program may be launched.
        if (start && (nib_cnt_r == 2'd0) && (count_r != {CW{1'b0}})) begin
          launch_s = 1'b1;
          state_s  = ST_RUN;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
`ifdef INSTR_STAGER_REPLAY_EN
        if (start) begin
          launch_s = 1'b1;
          state_s  = ST_RUN;
        end else begin
          state_s = ST_DONE;
        end
`else
        state_s = ST_DONE;
`endif
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // clear overrides every other transition.
    if (clear) begin
      state_s  = ST_IDLE;
      launch_s = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Program storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clock) begin
    if (write_s) begin
      mem_r[wr_ptr_r] <= {asm_r, nib_in};
    end
  end

  // Nibble assembly, pointers, issue sequencing and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nib_cnt_r     <= 2'd0;
      asm_r         <= 8'd0;
      wr_ptr_r      <= PTR_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      count_r       <= {CW{1'b0}};
      issued_r      <= {CW{1'b0}};
      instruction_r <= 12'd0;
      instr_valid_r <= 1'b0;
      proc_reset_r  <= 1'b1;
      done_r        <= 1'b0;
      overflow_r    <= 1'b0;
    end else if (clear) begin
      nib_cnt_r     <= 2'd0;
      asm_r         <= 8'd0;
      wr_ptr_r      <= PTR_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      count_r       <= {CW{1'b0}};
      issued_r      <= {CW{1'b0}};
      instruction_r <= 12'd0;
      instr_valid_r <= 1'b0;
      proc_reset_r  <= 1'b1;
      done_r        <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end

      if (accept_s) begin
        case (nib_cnt_r)
          2'd0: begin
            asm_r[7:4] <= nib_in;
            nib_cnt_r  <= 2'd1;
          end
          2'd1: begin
            asm_r[3:0] <= nib_in;
            nib_cnt_r  <= 2'd2;
          end
          default: begin
            nib_cnt_r <= 2'd0;
            wr_ptr_r  <= wr_ptr_r + PTR_ONE;
            count_r   <= count_r + CNT_ONE;
          end
        endcase
      end

      if (launch_s) begin
        // First word goes out on the launch edge; reads continue from slot 1.
        instruction_r <= mem_r[PTR_ZERO];
        instr_valid_r <= 1'b1;
        proc_reset_r  <= 1'b0;
        done_r        <= 1'b0;
        rd_ptr_r      <= PTR_ONE;
        issued_r      <= CNT_ONE;
      end else if (state_r == ST_RUN) begin
        if (last_s) begin
          instruction_r <= 12'd0;
          instr_valid_r <= 1'b0;
          proc_reset_r  <= 1'b1;
          done_r        <= 1'b1;
        end else begin
          instruction_r <= mem_r[rd_ptr_r];
          rd_ptr_r      <= rd_ptr_r + PTR_ONE;
          issued_r      <= issued_r + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_stager.sv
module tb_instr_stager;

  logic        clock;
  logic        reset;
  logic [3:0]  nib_in;
  logic        nib_valid;
  logic        nib_ready;
  logic        start;
  logic        clear;
  logic [11:0] instruction;
  logic        instr_valid;
  logic        proc_reset;
  logic [3:0]  count;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [11:0] fill_tab [8];

  instr_stager #(.DEPTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .nib_in      (nib_in),
    .nib_valid   (nib_valid),
    .nib_ready   (nib_ready),
    .start       (start),
    .clear       (clear),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .proc_reset  (proc_reset),
    .count       (count),
    .done        (done),
    .overflow    (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] n);
    nib_in    = n;
    nib_valid = 1'b1;
    tick();
    nib_valid = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] w);
    send(w[11:8]);
    send(w[7:4]);
    send(w[3:0]);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    fill_tab[0] = 12'h012; fill_tab[1] = 12'h345;
    fill_tab[2] = 12'h678; fill_tab[3] = 12'h9AB;
    fill_tab[4] = 12'hCDE; fill_tab[5] = 12'hF01;
    fill_tab[6] = 12'h234; fill_tab[7] = 12'h567;

    reset = 1'b1; nib_in = 4'h0; nib_valid = 1'b0; start = 1'b0; clear = 1'b0;
    #23;
    chk("rst_instr",     32'(instruction), 32'h0);
    chk("rst_valid",     32'(instr_valid), 32'h0);
    chk("rst_prst",      32'(proc_reset),  32'h1);
    chk("rst_ready",     32'(nib_ready),   32'h1);
    chk("rst_count",     32'(count),       32'h0);
    chk("rst_done",      32'(done),        32'h0);
    chk("rst_ovf",       32'(overflow),    32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Two-instruction program.
    send(4'hA); send(4'hB); send(4'hC);
    chk("t1_count1",     32'(count), 32'h1);
    send(4'h1); send(4'h2); send(4'h3);
    chk("t1_count2",     32'(count), 32'h2);
    chk("t1_prst_load",  32'(proc_reset), 32'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_i0",         32'(instruction), 32'hABC);
    chk("t1_v0",         32'(instr_valid), 32'h1);
    chk("t1_p0",         32'(proc_reset),  32'h0);
    chk("t1_ready_run",  32'(nib_ready),   32'h0);
    tick();
    chk("t1_i1",         32'(instruction), 32'h123);
    chk("t1_v1",         32'(instr_valid), 32'h1);
    chk("t1_p1",         32'(proc_reset),  32'h0);
    tick();
    chk("t1_done",       32'(done),        32'h1);
    chk("t1_instr_done", 32'(instruction), 32'h0);
    chk("t1_valid_done", 32'(instr_valid), 32'h0);
    chk("t1_prst_done",  32'(proc_reset),  32'h1);
    chk("t1_count_kept", 32'(count),       32'h2);
    chk("t1_ready_done", 32'(nib_ready),   32'h0);

    // start while in DONE.
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef INSTR_STAGER_REPLAY_EN
    chk("rp_i0",         32'(instruction), 32'hABC);
    chk("rp_p0",         32'(proc_reset),  32'h0);
    chk("rp_ready",      32'(nib_ready),   32'h0);
    tick();
    chk("rp_i1",         32'(instruction), 32'h123);
    tick();
    chk("rp_done",       32'(done),        32'h1);
`else
    chk("rp_instr",      32'(instruction), 32'h0);
    chk("rp_valid",      32'(instr_valid), 32'h0);
    chk("rp_done",       32'(done),        32'h1);
    tick();
    chk("rp_prst",       32'(proc_reset),  32'h1);
`endif

    pulse_clear();
    chk("clr_count",     32'(count), 32'h0);
    chk("clr_done",      32'(done),  32'h0);
    chk("clr_ready",     32'(nib_ready), 32'h1);

    // Partial instruction: start ignored.
    send(4'h4); send(4'h5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_valid",      32'(instr_valid), 32'h0);
    chk("t2_prst",       32'(proc_reset),  32'h1);
    chk("t2_count",      32'(count),       32'h0);
    send(4'h6);
    chk("t2_count1",     32'(count), 32'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_i0",         32'(instruction), 32'h456);
    chk("t2_v0",         32'(instr_valid), 32'h1);
    tick();
    chk("t2_done",       32'(done),        32'h1);
    chk("t2_prst_done",  32'(proc_reset),  32'h1);
    pulse_clear();

    // Fill to capacity, then overflow.
    for (int i = 0; i < 8; i++) send_word(fill_tab[i]);
    chk("t3_count_full", 32'(count),     32'h8);
    chk("t3_ready_full", 32'(nib_ready), 32'h0);
    chk("t3_ovf_before", 32'(overflow),  32'h0);
    send(4'hE);
    chk("t3_ovf",        32'(overflow),  32'h1);
    chk("t3_count_ovf",  32'(count),     32'h8);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_i0",         32'(instruction), 32'(fill_tab[0]));
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("t3_i%0d", k), 32'(instruction), 32'(fill_tab[k]));
      chk($sformatf("t3_p%0d", k), 32'(proc_reset),  32'h0);
    end
    tick();
    chk("t3_done",       32'(done),     32'h1);
    chk("t3_ovf_sticky", 32'(overflow), 32'h1);
    pulse_clear();
    chk("t3_ovf_clr",    32'(overflow), 32'h0);

    // clear beats start and nib_valid.
    send_word(12'h777);
    chk("t4_count1",     32'(count), 32'h1);
    clear = 1'b1; start = 1'b1; nib_in = 4'h9; nib_valid = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0; nib_valid = 1'b0;
    chk("t4_count",      32'(count),       32'h0);
    chk("t4_ovf",        32'(overflow),    32'h0);
    chk("t4_valid",      32'(instr_valid), 32'h0);
    chk("t4_prst",       32'(proc_reset),  32'h1);
    chk("t4_ready",      32'(nib_ready),   32'h1);
    tick();
    chk("t4_no_issue",   32'(instr_valid), 32'h0);
    chk("t4_count_hold", 32'(count),       32'h0);

    // Reset mid-RUN.
    send_word(12'h111); send_word(12'h222); send_word(12'h333);
    chk("t5_count",      32'(count), 32'h3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_i0",         32'(instruction), 32'h111);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_instr",  32'(instruction), 32'h0);
    chk("t5_rst_valid",  32'(instr_valid), 32'h0);
    chk("t5_rst_prst",   32'(proc_reset),  32'h1);
    chk("t5_rst_count",  32'(count),       32'h0);
    chk("t5_rst_ready",  32'(nib_ready),   32'h1);
    @(negedge clock);
    reset = 1'b0;
    tick();
    chk("t5_after_valid", 32'(instr_valid), 32'h0);
    chk("t5_after_done",  32'(done),        32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
